// File: rtl/chroma_key_multi.sv
// Multi-profile HSV chroma keyer: NUM_KEYS pushbutton-adjustable key windows, 2-stage match pipeline.
// Optional circular hue windows when CHROMA_KEY_HUE_WRAP_EN is defined.
module chroma_key_multi #(
  parameter int DATA_W      = 8,
  parameter int NUM_KEYS    = 2,
  parameter int KSEL_W      = 1,
  parameter int ADJ_DIV     = 16,
  parameter int H_NOM_INIT  = 85,
  parameter int S_NOM_INIT  = 94,
  parameter int V_NOM_INIT  = 202,
  parameter int RANGE_INIT  = 50,
  parameter int V_RANGE_POS = 50,
  parameter int V_RANGE_NEG = 100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vsync,
  input  logic                  pix_valid_in,
  input  logic [3*DATA_W-1:0]   hsv_in,
  input  logic                  up,
  input  logic                  down,
  input  logic                  left,
  input  logic                  right,
  input  logic [KSEL_W-1:0]     key_sel,
  output logic                  pix_valid_out,
  output logic [3*DATA_W-1:0]   hsv_out,
  output logic [NUM_KEYS-1:0]   match_mask,
  output logic                  match_any,
  output logic [DATA_W-1:0]     h_nom,
  output logic [DATA_W-1:0]     s_nom,
  output logic [DATA_W-1:0]     v_nom,
  output logic [DATA_W-1:0]     range
);

  localparam int                CNT_W    = (ADJ_DIV > 1) ? $clog2(ADJ_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ADJ_DIV - 1);
  localparam logic [DATA_W-1:0] H_INIT   = DATA_W'(H_NOM_INIT);
  localparam logic [DATA_W-1:0] S_INIT   = DATA_W'(S_NOM_INIT);
  localparam logic [DATA_W-1:0] V_INIT   = DATA_W'(V_NOM_INIT);
  localparam logic [DATA_W-1:0] R_INIT   = DATA_W'(RANGE_INIT);
  localparam logic [DATA_W-1:0] V_POS    = DATA_W'(V_RANGE_POS);
  localparam logic [DATA_W-1:0] V_NEG    = DATA_W'(V_RANGE_NEG);

  typedef enum logic {IDLE, HOLD} state_t;

  function automatic logic [DATA_W-1:0] sat_sub(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DATA_W] ? '1 : s[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] bump(input logic [DATA_W-1:0] x, input logic inc);
    if (inc) return (x == '1) ? x : x + DATA_W'(1);
    else     return (x == '0) ? x : x - DATA_W'(1);
  endfunction

  // ---------------- adjust FSM ----------------
  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             vsync_q_reg;
  logic             vs_fall, cmd, step_now;
  logic [1:0]       field;

  assign vs_fall  = vsync_q_reg & ~vsync;
  assign cmd      = up ^ down;
  assign field    = {left, right};
  assign step_now = vs_fall & cmd & ((state_reg == IDLE) | (cnt_reg == CNT_LAST));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      vsync_q_reg <= 1'b0;
    end else begin
      vsync_q_reg <= vsync;
      if (vs_fall) begin
        case (state_reg)
          IDLE: if (cmd) begin
            state_reg <= HOLD;
            cnt_reg   <= '0;
          end
          HOLD: begin
            if (!cmd)                     state_reg <= IDLE;
            else if (cnt_reg == CNT_LAST) cnt_reg   <= '0;
            else                          cnt_reg   <= cnt_reg + CNT_W'(1);
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  // ---------------- per-key profiles and window compare ----------------
  logic [NUM_KEYS*DATA_W-1:0] h_all, s_all, v_all, r_all;
  logic [NUM_KEYS-1:0]        hit_vec;
  logic [DATA_W-1:0]          pix_h, pix_s, pix_v;

  assign pix_h = hsv_in[3*DATA_W-1 -: DATA_W];
  assign pix_s = hsv_in[2*DATA_W-1 -: DATA_W];
  assign pix_v = hsv_in[DATA_W-1:0];

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    logic [DATA_W-1:0] h_reg, s_reg, v_reg, r_reg;
    logic [DATA_W-1:0] h_lo, h_hi, s_lo, s_hi, v_lo, v_hi;
    logic              h_ok, sel_hit;

    // Out-of-range key_sel never equals any key index, so those steps are dropped.
    assign sel_hit = step_now & (key_sel == KSEL_W'(gi));

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        h_reg <= H_INIT;
        s_reg <= S_INIT;
        v_reg <= V_INIT;
        r_reg <= R_INIT;
      end else if (sel_hit) begin
        case (field)
          2'b00:   h_reg <= bump(h_reg, up);
          2'b10:   s_reg <= bump(s_reg, up);
          2'b01:   v_reg <= bump(v_reg, up);
          default: r_reg <= bump(r_reg, up);
        endcase
      end
    end

    always_comb begin
      s_lo = sat_sub(s_reg, r_reg);
      s_hi = sat_add(s_reg, r_reg);
      v_lo = sat_sub(v_reg, V_NEG);
      v_hi = sat_add(v_reg, V_POS);
`ifdef CHROMA_KEY_HUE_WRAP_EN
      h_lo = h_reg - r_reg;
      h_hi = h_reg + r_reg;
      if (r_reg[DATA_W-1])  h_ok = 1'b1;
      else if (h_lo > h_hi) h_ok = (pix_h >= h_lo) | (pix_h <= h_hi);
      else                  h_ok = (pix_h >= h_lo) & (pix_h <= h_hi);
`else
      h_lo = sat_sub(h_reg, r_reg);
      h_hi = sat_add(h_reg, r_reg);
      h_ok = (pix_h >= h_lo) & (pix_h <= h_hi);
`endif
    end

    assign hit_vec[gi] = h_ok & (pix_s >= s_lo) & (pix_s <= s_hi) & (pix_v >= v_lo) & (pix_v <= v_hi);
    assign h_all[gi*DATA_W +: DATA_W] = h_reg;
    assign s_all[gi*DATA_W +: DATA_W] = s_reg;
    assign v_all[gi*DATA_W +: DATA_W] = v_reg;
    assign r_all[gi*DATA_W +: DATA_W] = r_reg;
  end

  // ---------------- match pipeline ----------------
  // S1 captures the compare result, freezing the thresholds seen on entry.
  logic                valid_s1_reg;
  logic [NUM_KEYS-1:0] match_s1_reg;
  logic [3*DATA_W-1:0] hsv_s1_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_s1_reg  <= 1'b0;
      match_s1_reg  <= '0;
      hsv_s1_reg    <= '0;
      pix_valid_out <= 1'b0;
      match_mask    <= '0;
      match_any     <= 1'b0;
      hsv_out       <= '0;
    end else begin
      valid_s1_reg  <= pix_valid_in;
      match_s1_reg  <= pix_valid_in ? hit_vec : '0;
      hsv_s1_reg    <= hsv_in;
      pix_valid_out <= valid_s1_reg;
      match_mask    <= valid_s1_reg ? match_s1_reg : '0;
      match_any     <= valid_s1_reg & (|match_s1_reg);
      hsv_out       <= hsv_s1_reg;
    end
  end

  // ---------------- status readback ----------------
  logic [DATA_W-1:0] h_sel, s_sel, v_sel, r_sel;
  logic              key_ok;

  always_comb begin
    h_sel  = '0;
    s_sel  = '0;
    v_sel  = '0;
    r_sel  = '0;
    key_ok = 1'b0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (key_sel == KSEL_W'(k)) begin
        h_sel  = h_all[k*DATA_W +: DATA_W];
        s_sel  = s_all[k*DATA_W +: DATA_W];
        v_sel  = v_all[k*DATA_W +: DATA_W];
        r_sel  = r_all[k*DATA_W +: DATA_W];
        key_ok = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_nom <= key_ok ? H_INIT : '0;
      s_nom <= key_ok ? S_INIT : '0;
      v_nom <= key_ok ? V_INIT : '0;
      range <= key_ok ? R_INIT : '0;
    end else begin
      h_nom <= h_sel;
      s_nom <= s_sel;
      v_nom <= v_sel;
      range <= r_sel;
    end
  end

endmodule

// File: tb/tb_chroma_key_multi.sv
// Scoreboard bench for chroma_key_multi: expected masks from a small integer model of the key windows.
module tb_chroma_key_multi;

  localparam int NK = 2;

  logic          clk = 1'b0;
  logic          rst_n, vsync, pix_valid_in, up, down, left, right;
  logic [23:0]   hsv_in;
  logic [0:0]    key_sel;
  logic          pix_valid_out, match_any;
  logic [23:0]   hsv_out;
  logic [NK-1:0] match_mask;
  logic [7:0]    h_nom, s_nom, v_nom, range;

  always #5 clk = ~clk;

  chroma_key_multi dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .pix_valid_in(pix_valid_in), .hsv_in(hsv_in),
    .up(up), .down(down), .left(left), .right(right), .key_sel(key_sel),
    .pix_valid_out(pix_valid_out), .hsv_out(hsv_out), .match_mask(match_mask), .match_any(match_any),
    .h_nom(h_nom), .s_nom(s_nom), .v_nom(v_nom), .range(range)
  );

  int total = 0;
  int bad   = 0;
  int m_h[NK], m_s[NK], m_v[NK], m_r[NK];

  typedef struct packed {
    logic          v;
    logic [NK-1:0] mask;
    logic [23:0]   hsv;
  } exp_t;
  exp_t sb[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  function automatic logic [NK-1:0] model_mask(input int h, input int s, input int v);
    logic [NK-1:0] m;
    m = '0;
    for (int k = 0; k < NK; k++) begin
      int hl, hh, sl, sh, vl, vh;
      bit hok;
      sl = m_s[k] - m_r[k]; if (sl < 0) sl = 0;
      sh = m_s[k] + m_r[k]; if (sh > 255) sh = 255;
      vl = m_v[k] - 100;    if (vl < 0) vl = 0;
      vh = m_v[k] + 50;     if (vh > 255) vh = 255;
`ifdef CHROMA_KEY_HUE_WRAP_EN
      if (m_r[k] >= 128) hok = 1'b1;
      else begin
        hl = (m_h[k] - m_r[k]) & 255;
        hh = (m_h[k] + m_r[k]) & 255;
        hok = (hl <= hh) ? (h >= hl && h <= hh) : (h >= hl || h <= hh);
      end
`else
      hl = m_h[k] - m_r[k]; if (hl < 0) hl = 0;
      hh = m_h[k] + m_r[k]; if (hh > 255) hh = 255;
      hok = (h >= hl && h <= hh);
`endif
      m[k] = hok && s >= sl && s <= sh && v >= vl && v <= vh;
    end
    return m;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NK; k++) begin
      m_h[k] = 85; m_s[k] = 94; m_v[k] = 202; m_r[k] = 50;
    end
  endtask

  // One clock: check the entry driven two cycles ago, then drive and record the new one.
  task automatic cycle(input logic val, input logic [23:0] px);
    exp_t e;
    @(negedge clk);
    if (sb.size() == 2) begin
      e = sb.pop_front();
      check_val("valid", 32'(pix_valid_out), 32'(e.v));
      check_val("mask", 32'(match_mask), 32'(e.mask));
      check_val("any", 32'(match_any), 32'(|e.mask));
      if (e.v) begin
        check_val("hsv", 32'(hsv_out), 32'(e.hsv));
        $display("pixel h=%0d s=%0d v=%0d mask=%b want=%b", e.hsv[23:16], e.hsv[15:8], e.hsv[7:0], match_mask, e.mask);
      end
    end
    pix_valid_in = val;
    hsv_in       = px;
    e.v    = val;
    e.mask = val ? model_mask(int'(px[23:16]), int'(px[15:8]), int'(px[7:0])) : '0;
    e.hsv  = px;
    sb.push_back(e);
  endtask

  task automatic pix(input int h, input int s, input int v);
    cycle(1'b1, {8'(h), 8'(s), 8'(v)});
  endtask

  task automatic flush();
    repeat (3) cycle(1'b0, 24'h0);
  endtask

  task automatic frame();
    vsync = 1'b1;
    cycle(1'b0, 24'h0);
    cycle(1'b0, 24'h0);
    vsync = 1'b0;
    cycle(1'b0, 24'h0);
    cycle(1'b0, 24'h0);
  endtask

  task automatic press(input int n, input logic inc);
    repeat (n) begin
      up = inc; down = !inc;
      frame();
      up = 1'b0; down = 1'b0;
      frame();
    end
  endtask

  task automatic check_status(input int h, input int s, input int v, input int r);
    check_val("h_nom", 32'(h_nom), 32'(h));
    check_val("s_nom", 32'(s_nom), 32'(s));
    check_val("v_nom", 32'(v_nom), 32'(v));
    check_val("range", 32'(range), 32'(r));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pix_valid_in = 1'b0;
    vsync = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_valid", 32'(pix_valid_out), 32'd0);
    check_val("rst_mask", 32'(match_mask), 32'd0);
    check_val("rst_any", 32'(match_any), 32'd0);
    check_val("rst_hsv", 32'(hsv_out), 32'd0);
    check_status(85, 94, 202, 50);
    sb.delete();
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; vsync = 1'b0; pix_valid_in = 1'b0; hsv_in = '0;
    up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0; key_sel = 1'b0;
    do_reset();

    // Basic match and V window edges at reset profiles
    pix(85, 94, 202);
    pix(85, 94, 101);
    pix(85, 94, 102);
    pix(85, 94, 252);
    pix(85, 94, 255);
    pix(35, 44, 150);
    pix(34, 94, 202);
    flush();

    // Hold up on key1 hue: steps at falls 1, 17, 33
    key_sel = 1'b1; left = 1'b0; right = 1'b0; up = 1'b1;
    repeat (16) frame();
    check_val("hold16", 32'(h_nom), 32'd86);
    frame();
    check_val("hold17", 32'(h_nom), 32'd87);
    repeat (15) frame();
    check_val("hold32", 32'(h_nom), 32'd87);
    frame();
    check_val("hold33", 32'(h_nom), 32'd88);
    up = 1'b0;
    frame();
    m_h[1] = 88;
    key_sel = 1'b0;
    cycle(1'b0, 24'h0);
    check_val("key0_h", 32'(h_nom), 32'd85);
    up = 1'b1; down = 1'b1;
    repeat (3) frame();
    check_val("both_held", 32'(h_nom), 32'd85);
    up = 1'b0; down = 1'b0;
    frame();
    pix(136, 94, 202);
    pix(138, 94, 202);
    pix(139, 94, 202);
    flush();

    // Range of key0 saturates at 0
    left = 1'b1; right = 1'b1;
    press(60, 1'b0);
    check_val("range_sat0", 32'(range), 32'd0);
    m_r[0] = 0;
    pix(85, 94, 202);
    pix(86, 94, 202);
    pix(85, 95, 202);
    flush();

    // Key0: restore range, move hue to 10
    press(50, 1'b1);
    left = 1'b0; right = 1'b0;
    press(75, 1'b0);
    check_status(10, 94, 202, 50);
    m_r[0] = 50; m_h[0] = 10;
    pix(250, 94, 202);
    pix(0, 94, 202);
    pix(60, 94, 202);
    pix(61, 94, 202);
    flush();

    // Key1 V saturates at 255
    key_sel = 1'b1; left = 1'b0; right = 1'b1;
    press(60, 1'b1);
    check_status(88, 94, 255, 50);
    m_v[1] = 255;
    pix(88, 94, 255);
    pix(88, 94, 155);
    pix(88, 94, 154);

    // Reset mid-stream with up held
    key_sel = 1'b0; left = 1'b0; right = 1'b0; up = 1'b1;
    pix(88, 94, 255);
    do_reset();
    repeat (2) cycle(1'b0, 24'h0);
    check_val("post_rst_valid", 32'(pix_valid_out), 32'd0);
    frame();
    check_val("post_rst_step", 32'(h_nom), 32'd86);
    up = 1'b0;
    frame();
    m_h[0] = 86;
    pix(85, 94, 202);
    pix(136, 94, 202);
    pix(135, 94, 202);
    flush();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
